// File: rtl/dmem_responder_if.sv
// Request/response channel between the core's MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_is_store;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding byte/half/word load or store per request.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (faults misaligned half/word accesses).
module dmem_responder #(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_op;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_is_store;

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [DATA_WIDTH-1:0]   w_rword;
    logic                    w_range_err;
    logic                    w_misalign;
    logic                    w_err;
    logic                    w_is_store;
    logic                    w_we;
    logic [3:0]              w_be;
    logic [31:0]             w_wlanes;

    function automatic logic op_is_valid(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_is_valid = 1'b1;
            default:             op_is_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_SB:   byte_enables = 4'b0001 << addr_lo;
            OP_SH:   byte_enables = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_SW:   byte_enables = 4'b1111;
            default: byte_enables = 4'b0000;
        endcase
    endfunction

    // Replicating the store data puts the right-aligned value under every candidate lane.
    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] wdata);
        case (op)
            OP_SB:   store_lanes = {4{wdata[7:0]}};
            OP_SH:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] addr_lo,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {addr_lo, 3'b000};
        b       = shifted[7:0];
        h       = addr_lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_extend = {{24{b[7]}}, b};
            OP_LBU:  load_extend = {24'h000000, b};
            OP_LH:   load_extend = {{16{h[15]}}, h};
            OP_LHU:  load_extend = {16'h0000, h};
            OP_LW:   load_extend = word;
            default: load_extend = 32'h00000000;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = addr_lo[0];
            OP_LW, OP_SW:         is_misaligned = (addr_lo != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    assign w_misalign = is_misaligned(r_op, r_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_idx       = r_addr[ADDR_WIDTH+1:2];
    assign w_rword     = r_mem[w_idx];
    assign w_range_err = |r_addr[31:ADDR_WIDTH+2];
    assign w_err       = w_range_err || !op_is_valid(r_op) || w_misalign;
    assign w_is_store  = r_op[3];
    // A low reset on the ACCESS edge must not leave a partial store behind.
    assign w_we        = rst_n && (r_state == ST_ACCESS) && !w_err && w_is_store;
    assign w_be        = byte_enables(r_op, r_addr[1:0]);
    assign w_wlanes    = store_lanes(r_op, r_wdata);

    assign bus.req_ready    = (r_state == ST_IDLE) && rst_n;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.rsp_is_store = r_rsp_is_store;

    // Next-state logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= 4'h0;
            r_addr  <= 32'h00000000;
            r_wdata <= 32'h00000000;
        end else if ((r_state == ST_IDLE) && bus.req_valid) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // Response registers: loaded at the end of ACCESS, held until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 32'h00000000;
            r_rsp_err      <= 1'b0;
            r_rsp_is_store <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_err      <= w_err;
            r_rsp_is_store <= w_is_store;
            r_rsp_rdata    <= (w_err || w_is_store) ? 32'h00000000
                                                    : load_extend(r_op, r_addr[1:0], w_rword);
        end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 32'h00000000;
            r_rsp_err      <= 1'b0;
            r_rsp_is_store <= 1'b0;
        end
    end

    // Byte-lane write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: expected responses are queued at request time.
module tb_dmem_responder;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1010;
    localparam logic [3:0] NOP = 4'b0011;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_store;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;
    exp_t sb_q[$];

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(4096), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One full transaction; stall = cycles rsp_ready is withheld while req_valid is held high.
    task automatic do_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int stall);
        exp_t e;
        int   n;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        e.is_store = op[3];
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, {31'b0, n < 20}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, "_valid_in_access"}, {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid_latency"}, {31'b0, bus.rsp_valid}, 32'd1);
        e = sb_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            check({tag, "_stall_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, bus.rsp_rdata, e.rdata);
            check({tag, "_stall_ready"}, {31'b0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
        check({tag, "_is_store"}, {31'b0, bus.rsp_is_store}, {31'b0, e.is_store});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_valid_after"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks_total  = 0;
        checks_passed = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = NOP;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_rsp_is_store", {31'b0, bus.rsp_is_store}, 32'd0);
        rst_n = 1'b1;

        do_req("sw_10",  SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        do_req("lw_10",  LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        do_req("sw_10z", SW,  32'h10, 32'h0,        32'h0,        1'b0, 0);
        do_req("sb_13",  SB,  32'h13, 32'h80,       32'h0,        1'b0, 0);
        do_req("lb_13",  LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 0);
        do_req("lbu_13", LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 0);
        do_req("lw_10b", LW,  32'h10, 32'h0,        32'h80000000, 1'b0, 0);

        do_req("sw_20",  SW,  32'h20, 32'h11111111, 32'h0,        1'b0, 0);
        do_req("sh_22",  SH,  32'h22, 32'h1234ABCD, 32'h0,        1'b0, 0);
        do_req("lw_20",  LW,  32'h20, 32'h0,        32'hABCD1111, 1'b0, 0);
        do_req("lh_22",  LH,  32'h22, 32'h0,        32'hFFFFABCD, 1'b0, 0);
        do_req("lhu_22", LHU, 32'h22, 32'h0,        32'h0000ABCD, 1'b0, 0);

        do_req("lw_oor",  LW,    32'h4000, 32'h0,        32'h0, 1'b1, 0);
        do_req("sw_oor",  SW,    32'h4020, 32'h55555555, 32'h0, 1'b1, 0);
        do_req("nop",     NOP,   32'h10,   32'h0,        32'h0, 1'b1, 0);
        do_req("bad_op",  4'hF,  32'h20,   32'h77777777, 32'h0, 1'b1, 0);
        do_req("lw_20_kept", LW, 32'h20,   32'h0,        32'hABCD1111, 1'b0, 0);
        do_req("lw_10_kept", LW, 32'h10,   32'h0,        32'h80000000, 1'b0, 0);

`ifdef DMEM_MISALIGN_CHECK_EN
        do_req("sw_21",  SW,  32'h21, 32'hCAFEF00D, 32'h0,        1'b1, 0);
        do_req("lw_20m", LW,  32'h20, 32'h0,        32'hABCD1111, 1'b0, 0);
        do_req("lhu_21", LHU, 32'h21, 32'h0,        32'h0,        1'b1, 0);
`else
        do_req("sw_21",  SW,  32'h21, 32'hCAFEF00D, 32'h0,        1'b0, 0);
        do_req("lw_20m", LW,  32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 0);
        do_req("lhu_21", LHU, 32'h21, 32'h0,        32'h0000F00D, 1'b0, 0);
`endif

        do_req("stall", LW, 32'h10, 32'h0, 32'h80000000, 1'b0, 5);

        // Reset asserted during the ACCESS cycle of a store must drop it.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = SW;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'hFFFFFFFF;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstacc_accept", {31'b0, n < 20}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        check("rstacc_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rstacc_req_ready", {31'b0, bus.req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstacc_ready_after", {31'b0, bus.req_ready}, 32'd1);
        do_req("lw_10_after_rst", LW, 32'h10, 32'h0, 32'h80000000, 1'b0, 0);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
